// File: rtl/blast_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// blast_pkg : shared constants, state encoding and score type
// Rev 1.0
// ------------------------------------------------------------------
package blast_pkg;

  localparam int BASE_W   = 2;
  localparam int SEED_LEN = 11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CAPTURE = 3'd1,
    EXT_R   = 3'd2,
    EXT_L   = 3'd3,
    REPORT  = 3'd4
  } state_t;

  typedef logic signed [11:0] score_t;

endpackage
`default_nettype wire

// File: rtl/xdrop_tracker.sv
`default_nettype none
// ------------------------------------------------------------------
// xdrop_tracker : running score / best score shared by both directions
// Rev 1.0
// ------------------------------------------------------------------
module xdrop_tracker #(
  parameter int unsigned MATCH    = 1,
  parameter int unsigned MISMATCH = 1,
  parameter int unsigned XDROP    = 10,
  parameter int          SCORE_W  = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      init,
  input  logic signed [SCORE_W-1:0] init_val,
  input  logic                      step,
  input  logic                      match,
  output logic signed [SCORE_W-1:0] best_step,
  output logic                      improve,
  output logic                      drop
);

  localparam logic signed [SCORE_W-1:0] C_MATCH    = SCORE_W'(MATCH);
  localparam logic signed [SCORE_W-1:0] C_MISMATCH = SCORE_W'(MISMATCH);
  localparam logic signed [SCORE_W-1:0] C_XDROP    = SCORE_W'(XDROP);

  logic signed [SCORE_W-1:0] score_q, score_d;
  logic signed [SCORE_W-1:0] best_q, best_d;
  logic signed [SCORE_W-1:0] stepped;

  // improve/drop/best_step describe the result of stepping this cycle
  always_comb begin
    stepped   = match ? (score_q + C_MATCH) : (score_q - C_MISMATCH);
    improve   = stepped > best_q;
    best_step = improve ? stepped : best_q;
    drop      = (best_step - stepped) > C_XDROP;
    score_d   = score_q;
    best_d    = best_q;
    if (init) begin
      score_d = init_val;
      best_d  = init_val;
    end else if (step) begin
      score_d = stepped;
      best_d  = best_step;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      score_q <= '0;
      best_q  <= '0;
    end else begin
      score_q <= score_d;
      best_q  <= best_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ungapped_extend.sv
`default_nettype none
// ------------------------------------------------------------------
// ungapped_extend : X-drop ungapped extension of an 11-base seed
// Rev 1.0
// ------------------------------------------------------------------
module ungapped_extend
  import blast_pkg::*;
#(
  parameter int unsigned QLEN_BP    = 256,
  parameter int unsigned DLEN_BP    = 256,
  parameter int unsigned MATCH      = 1,
  parameter int unsigned MISMATCH   = 1,
  parameter int unsigned XDROP      = 10,
  parameter int unsigned HSP_THRESH = 20,
  parameter int          SCORE_W    = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [511:0]              query,
  input  logic                      queryValid,
  input  logic [511:0]              dataBase,
  input  logic                      dataBaseValid,
  input  logic                      startExpand,
  input  logic [8:0]                locationQ,
  input  logic [8:0]                ShiftNo,
  output logic                      stop,
  output logic                      hspValid,
  output logic signed [SCORE_W-1:0] hspScore,
  output logic [8:0]                hspQStart,
  output logic [8:0]                hspQEnd,
  output logic [8:0]                hspDStart,
  output logic [8:0]                hspDEnd,
  output logic                      busy
);

  localparam int IDX_W = 9;
  typedef logic [IDX_W-1:0] idx_t;

  localparam idx_t C_SEED = idx_t'(SEED_LEN);
  localparam idx_t C_QLEN = idx_t'(QLEN_BP);
  localparam idx_t C_DLEN = idx_t'(DLEN_BP);
  localparam logic signed [SCORE_W-1:0] C_SEED_SCORE = SCORE_W'(SEED_LEN * MATCH);
  localparam logic signed [SCORE_W-1:0] C_THRESH     = SCORE_W'(HSP_THRESH);

  state_t       state_q, state_d;
  logic         start_dly_q, start_dly_d;
  logic [511:0] qbuf_q, qbuf_d, dbuf_q, dbuf_d;
  logic [511:0] qwork_q, qwork_d, dwork_q, dwork_d;
  idx_t         qs_q, qs_d, ds_q, ds_d, qi_q, qi_d, di_q, di_d;
  idx_t         cnt_q, cnt_d, rbest_q, rbest_d, lbest_q, lbest_d;
  logic signed [SCORE_W-1:0] hsp_score_q, hsp_score_d;
  logic [8:0]   hsp_qs_q, hsp_qs_d, hsp_qe_q, hsp_qe_d;
  logic [8:0]   hsp_ds_q, hsp_ds_d, hsp_de_q, hsp_de_d;

  idx_t         w_qs, w_ds;
  logic         w_r_empty, w_l_empty_in, w_l_empty_q, w_match, load_hsp;
  logic [7:0]   w_qstart, w_qend, w_dstart, w_dend;
  logic signed [SCORE_W-1:0] w_best_fin;
  logic         trk_init, trk_step, trk_improve, trk_drop;
  logic signed [SCORE_W-1:0] trk_init_val, trk_best_step;

  assign w_qs         = idx_t'(locationQ >> 1);
  assign w_ds         = idx_t'(ShiftNo >> 1);
  assign w_r_empty    = (w_qs + C_SEED >= C_QLEN) || (w_ds + C_SEED >= C_DLEN);
  assign w_l_empty_in = (w_qs == '0) || (w_ds == '0);
  assign w_l_empty_q  = (qs_q == '0) || (ds_q == '0);
  assign w_match      = qwork_q[{qi_q[7:0], 1'b0} +: BASE_W] == dwork_q[{di_q[7:0], 1'b0} +: BASE_W];

  xdrop_tracker #(
    .MATCH    (MATCH),
    .MISMATCH (MISMATCH),
    .XDROP    (XDROP),
    .SCORE_W  (SCORE_W)
  ) u_trk (
    .clk       (clk),
    .rst       (rst),
    .init      (trk_init),
    .init_val  (trk_init_val),
    .step      (trk_step),
    .match     (w_match),
    .best_step (trk_best_step),
    .improve   (trk_improve),
    .drop      (trk_drop)
  );

  always_comb begin
    state_d      = state_q;
    start_dly_d  = startExpand;
    qbuf_d       = queryValid ? query : qbuf_q;
    dbuf_d       = dataBaseValid ? dataBase : dbuf_q;
    qwork_d      = qwork_q;
    dwork_d      = dwork_q;
    qs_d         = qs_q;
    ds_d         = ds_q;
    qi_d         = qi_q;
    di_d         = di_q;
    cnt_d        = cnt_q;
    rbest_d      = rbest_q;
    lbest_d      = lbest_q;
    hsp_score_d  = hsp_score_q;
    hsp_qs_d     = hsp_qs_q;
    hsp_qe_d     = hsp_qe_q;
    hsp_ds_d     = hsp_ds_q;
    hsp_de_d     = hsp_de_q;
    trk_init     = 1'b0;
    trk_step     = 1'b0;
    trk_init_val = C_SEED_SCORE;
    w_best_fin   = trk_best_step;
    load_hsp     = 1'b0;

    case (state_q)
      IDLE: begin
        if (startExpand && !start_dly_q) state_d = CAPTURE;
      end
      CAPTURE: begin
        qs_d       = w_qs;
        ds_d       = w_ds;
        qwork_d    = qbuf_q;
        dwork_d    = dbuf_q;
        trk_init   = 1'b1;
        rbest_d    = '0;
        lbest_d    = '0;
        cnt_d      = idx_t'(1);
        w_best_fin = C_SEED_SCORE;
        // zero-step directions are skipped so latency counts only real steps
        if (!w_r_empty) begin
          state_d = EXT_R;
          qi_d    = w_qs + C_SEED;
          di_d    = w_ds + C_SEED;
        end else if (!w_l_empty_in) begin
          state_d = EXT_L;
          qi_d    = w_qs - idx_t'(1);
          di_d    = w_ds - idx_t'(1);
        end else begin
          state_d  = REPORT;
          load_hsp = 1'b1;
        end
      end
      EXT_R: begin
        trk_step = 1'b1;
        qi_d     = qi_q + idx_t'(1);
        di_d     = di_q + idx_t'(1);
        cnt_d    = cnt_q + idx_t'(1);
        if (trk_improve) rbest_d = cnt_q;
        if (trk_drop || (qi_q + idx_t'(1) >= C_QLEN) || (di_q + idx_t'(1) >= C_DLEN)) begin
          cnt_d = idx_t'(1);
          if (!w_l_empty_q) begin
            state_d      = EXT_L;
            qi_d         = qs_q - idx_t'(1);
            di_d         = ds_q - idx_t'(1);
            trk_init     = 1'b1;
            trk_init_val = trk_best_step;
          end else begin
            state_d  = REPORT;
            load_hsp = 1'b1;
          end
        end
      end
      EXT_L: begin
        trk_step = 1'b1;
        qi_d     = qi_q - idx_t'(1);
        di_d     = di_q - idx_t'(1);
        cnt_d    = cnt_q + idx_t'(1);
        if (trk_improve) lbest_d = cnt_q;
        if (trk_drop || (qi_q == '0) || (di_q == '0)) begin
          state_d  = REPORT;
          load_hsp = 1'b1;
        end
      end
      REPORT: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // best counters hold the step number of the last improvement (0 = none)
    w_qstart = 8'(qs_d - lbest_d);
    w_dstart = 8'(ds_d - lbest_d);
    w_qend   = 8'(qs_d + C_SEED - idx_t'(1) + rbest_d);
    w_dend   = 8'(ds_d + C_SEED - idx_t'(1) + rbest_d);
    if (load_hsp) begin
      hsp_score_d = w_best_fin;
      hsp_qs_d    = {w_qstart, 1'b0};
      hsp_qe_d    = {w_qend, 1'b0};
      hsp_ds_d    = {w_dstart, 1'b0};
      hsp_de_d    = {w_dend, 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      start_dly_q <= 1'b0;
      qbuf_q      <= '0;
      dbuf_q      <= '0;
      qwork_q     <= '0;
      dwork_q     <= '0;
      qs_q        <= '0;
      ds_q        <= '0;
      qi_q        <= '0;
      di_q        <= '0;
      cnt_q       <= '0;
      rbest_q     <= '0;
      lbest_q     <= '0;
      hsp_score_q <= '0;
      hsp_qs_q    <= '0;
      hsp_qe_q    <= '0;
      hsp_ds_q    <= '0;
      hsp_de_q    <= '0;
    end else begin
      state_q     <= state_d;
      start_dly_q <= start_dly_d;
      qbuf_q      <= qbuf_d;
      dbuf_q      <= dbuf_d;
      qwork_q     <= qwork_d;
      dwork_q     <= dwork_d;
      qs_q        <= qs_d;
      ds_q        <= ds_d;
      qi_q        <= qi_d;
      di_q        <= di_d;
      cnt_q       <= cnt_d;
      rbest_q     <= rbest_d;
      lbest_q     <= lbest_d;
      hsp_score_q <= hsp_score_d;
      hsp_qs_q    <= hsp_qs_d;
      hsp_qe_q    <= hsp_qe_d;
      hsp_ds_q    <= hsp_ds_d;
      hsp_de_q    <= hsp_de_d;
    end
  end

  assign stop      = (state_q == REPORT) && !rst;
  assign hspValid  = stop && (hsp_score_q >= C_THRESH);
  assign busy      = (state_q != IDLE) && !rst;
  assign hspScore  = hsp_score_q;
  assign hspQStart = hsp_qs_q;
  assign hspQEnd   = hsp_qe_q;
  assign hspDStart = hsp_ds_q;
  assign hspDEnd   = hsp_de_q;

endmodule
`default_nettype wire

// File: tb/tb_ungapped_extend.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_ungapped_extend : scoreboard bench for ungapped_extend
// Rev 1.0
// ------------------------------------------------------------------
module tb_ungapped_extend;

  logic               clk = 1'b0;
  logic               rst;
  logic [511:0]       query, dataBase;
  logic               queryValid, dataBaseValid, startExpand;
  logic [8:0]         locationQ, ShiftNo;
  logic               stop, hspValid, busy;
  logic signed [11:0] hspScore;
  logic [8:0]         hspQStart, hspQEnd, hspDStart, hspDEnd;

  always #5 clk = ~clk;

  ungapped_extend dut (
    .clk           (clk),
    .rst           (rst),
    .query         (query),
    .queryValid    (queryValid),
    .dataBase      (dataBase),
    .dataBaseValid (dataBaseValid),
    .startExpand   (startExpand),
    .locationQ     (locationQ),
    .ShiftNo       (ShiftNo),
    .stop          (stop),
    .hspValid      (hspValid),
    .hspScore      (hspScore),
    .hspQStart     (hspQStart),
    .hspQEnd       (hspQEnd),
    .hspDStart     (hspDStart),
    .hspDEnd       (hspDEnd),
    .busy          (busy)
  );

  typedef struct packed {
    logic signed [11:0] score;
    logic [8:0]         qs;
    logic [8:0]         qe;
    logic [8:0]         ds;
    logic [8:0]         de;
    logic               valid;
    logic [15:0]        lat;
  } res_t;

  res_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   stop_cnt = 0;
  int   hv_cnt = 0;
  int   hv_stray = 0;

  always @(posedge clk) begin
    #1;
    if (stop) stop_cnt++;
    if (hspValid) hv_cnt++;
    if (hspValid && !stop) hv_stray++;
  end

  function automatic logic [1:0] get_base(logic [511:0] v, int i);
    return v[2*i +: 2];
  endfunction

  function automatic logic [511:0] set_base(logic [511:0] v, int i, logic [1:0] b);
    logic [511:0] r;
    r = v;
    r[2*i +: 2] = b;
    return r;
  endfunction

  function automatic logic [511:0] rand_vec();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[32*i +: 32] = $urandom();
    return v;
  endfunction

  function automatic string fmt(res_t r);
    return $sformatf("score=%0d qs=%0d qe=%0d ds=%0d de=%0d valid=%0b lat=%0d",
                     r.score, r.qs, r.qe, r.ds, r.de, r.valid, r.lat);
  endfunction

  function automatic res_t mk(int sc, int qs, int qe, int ds, int de, bit v, int lat);
    res_t r;
    r.score = 12'(sc); r.qs = 9'(qs); r.qe = 9'(qe); r.ds = 9'(ds); r.de = 9'(de);
    r.valid = v; r.lat = 16'(lat);
    return r;
  endfunction

  // behavioural reference: seed score 11, +1/-1 steps, X-drop 10, threshold 20
  function automatic res_t model(logic [511:0] q, logic [511:0] d, int qs, int ds);
    int score, best, n, re, ls, i, j;
    score = 11; best = 11; re = qs + 10; ls = qs; n = 0;
    if (qs + 11 < 256 && ds + 11 < 256) begin
      i = qs + 11; j = ds + 11;
      for (int k = 0; k < 256; k++) begin
        n++;
        score += (get_base(q, i) == get_base(d, j)) ? 1 : -1;
        if (score > best) begin best = score; re = i; end
        if (best - score > 10) break;
        if (i + 1 >= 256 || j + 1 >= 256) break;
        i++; j++;
      end
    end
    score = best;
    if (qs > 0 && ds > 0) begin
      i = qs - 1; j = ds - 1;
      for (int k = 0; k < 256; k++) begin
        n++;
        score += (get_base(q, i) == get_base(d, j)) ? 1 : -1;
        if (score > best) begin best = score; ls = i; end
        if (best - score > 10) break;
        if (i == 0 || j == 0) break;
        i--; j--;
      end
    end
    return mk(best, 2*ls, 2*re, 2*(ds - (qs - ls)), 2*(ds + re - qs), best >= 20, 2 + n);
  endfunction

  task automatic load(input logic [511:0] q, input logic [511:0] d);
    @(negedge clk);
    query = q; dataBase = d; queryValid = 1'b1; dataBaseValid = 1'b1;
    @(negedge clk);
    queryValid = 1'b0; dataBaseValid = 1'b0;
  endtask

  // raises startExpand at a negedge; lat counts posedges from the sampling edge
  task automatic launch(input int qs, input int ds, output res_t o, output bit to);
    locationQ = 9'(2*qs); ShiftNo = 9'(2*ds); startExpand = 1'b1;
    o = '0; to = 1'b1;
    for (int i = 1; i <= 2000; i++) begin
      @(posedge clk); #1;
      if (stop) begin
        o = mk(int'(hspScore), int'(hspQStart), int'(hspQEnd), int'(hspDStart),
               int'(hspDEnd), hspValid, i);
        to = 1'b0;
        break;
      end
    end
    @(negedge clk);
    startExpand = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; startExpand = 1'b0; queryValid = 1'b0; dataBaseValid = 1'b0;
    query = '0; dataBase = '0; locationQ = '0; ShiftNo = '0;
    repeat (3) @(negedge clk);
    startExpand = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({stop, hspValid, busy} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_flags: stop/hspValid/busy=%b required 000", {stop, hspValid, busy});
    end
    vectors++;
    if (hspScore !== 12'sd0) begin
      miscompares++;
      $display("FAIL reset_score: got %0d required 0", hspScore);
    end
    vectors++;
    if ({hspQStart, hspQEnd, hspDStart, hspDEnd} !== 36'd0) begin
      miscompares++;
      $display("FAIL reset_pos: got %0d %0d %0d %0d required all 0", hspQStart, hspQEnd, hspDStart, hspDEnd);
    end
    @(negedge clk);
    startExpand = 1'b0; rst = 1'b0;
    repeat (4) @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_wins: busy=%b required 0 after start edge under reset", busy);
    end
  endtask

  task automatic test_full_match();
    logic [511:0] q;
    res_t o, e;
    bit to;
    q = rand_vec();
    load(q, q);
    exp_q.push_back(mk(256, 0, 510, 0, 510, 1'b1, 247));
    launch(100, 100, o, to);
    e = exp_q.pop_front();
    vectors++;
    if (to || o !== e) begin
      miscompares++;
      $display("FAIL full_match: got %s timeout=%0b, required %s", fmt(o), to, fmt(e));
    end
  endtask

  task automatic test_all_mismatch();
    logic [511:0] q, d, m;
    res_t o, e;
    bit to;
    q = rand_vec();
    m = {256{2'b01}};
    d = q ^ m;
    for (int i = 50; i <= 60; i++) d = set_base(d, i, get_base(q, i));
    load(q, d);
    exp_q.push_back(mk(11, 100, 120, 100, 120, 1'b0, 24));
    launch(50, 50, o, to);
    e = exp_q.pop_front();
    vectors++;
    if (to || o !== e) begin
      miscompares++;
      $display("FAIL all_mismatch: got %s timeout=%0b, required %s", fmt(o), to, fmt(e));
    end
  endtask

  task automatic test_edge_seed();
    res_t o, e;
    bit to;
    load(rand_vec(), rand_vec());
    exp_q.push_back(mk(11, 0, 20, 490, 510, 1'b0, 2));
    launch(0, 245, o, to);
    e = exp_q.pop_front();
    vectors++;
    if (to || o !== e) begin
      miscompares++;
      $display("FAIL edge_seed: got %s timeout=%0b, required %s", fmt(o), to, fmt(e));
    end
  endtask

  // best of 20 must report, best of 19 must not
  task automatic test_threshold();
    logic [511:0] q, d, m;
    res_t o, e;
    bit to;
    for (int nm = 9; nm >= 8; nm--) begin
      q = rand_vec();
      m = {256{2'b01}};
      d = q ^ m;
      for (int i = 100; i <= 110 + nm; i++) d = set_base(d, i, get_base(q, i));
      load(q, d);
      exp_q.push_back(mk(11 + nm, 200, 2*(110 + nm), 200, 2*(110 + nm), nm == 9, 2 + nm + 11 + 11));
      launch(100, 100, o, to);
      e = exp_q.pop_front();
      vectors++;
      if (to || o !== e) begin
        miscompares++;
        $display("FAIL threshold_%0d: got %s timeout=%0b, required %s", 11 + nm, fmt(o), to, fmt(e));
      end
    end
  endtask

  task automatic test_held_start();
    logic [511:0] q, d, m;
    int s0, h0;
    q = rand_vec();
    m = {256{2'b01}};
    d = q ^ m;
    for (int i = 50; i <= 60; i++) d = set_base(d, i, get_base(q, i));
    load(q, d);
    s0 = stop_cnt; h0 = hv_cnt;
    locationQ = 9'd100; ShiftNo = 9'd100; startExpand = 1'b1;
    repeat (300) @(negedge clk);
    startExpand = 1'b0;
    repeat (30) @(negedge clk);
    vectors++;
    if (stop_cnt - s0 !== 1) begin
      miscompares++;
      $display("FAIL held_start: stop pulses=%0d required 1", stop_cnt - s0);
    end
    vectors++;
    if (hv_cnt - h0 !== 0 || hspScore !== 12'sd11) begin
      miscompares++;
      $display("FAIL held_result: hspValid pulses=%0d score=%0d required 0 and 11", hv_cnt - h0, hspScore);
    end
  endtask

  task automatic test_reset_mid();
    logic [511:0] q;
    res_t o, e;
    bit to;
    int s0, h0;
    q = rand_vec();
    load(q, q);
    s0 = stop_cnt; h0 = hv_cnt;
    locationQ = 9'd200; ShiftNo = 9'd200; startExpand = 1'b1;
    repeat (20) @(negedge clk);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_busy: busy=%b required 1 during extension", busy);
    end
    rst = 1'b1; startExpand = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_abort_busy: busy=%b required 0", busy);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (300) @(negedge clk);
    vectors++;
    if (stop_cnt !== s0 || hv_cnt !== h0) begin
      miscompares++;
      $display("FAIL mid_abort_pulses: stop=%0d hspValid=%0d required 0 and 0", stop_cnt - s0, hv_cnt - h0);
    end
    load(q, q);
    exp_q.push_back(mk(256, 0, 510, 0, 510, 1'b1, 247));
    launch(100, 100, o, to);
    e = exp_q.pop_front();
    vectors++;
    if (to || o !== e) begin
      miscompares++;
      $display("FAIL mid_restart: got %s timeout=%0b, required %s", fmt(o), to, fmt(e));
    end
  endtask

  task automatic test_db_pulse();
    logic [511:0] q;
    res_t o, e;
    bit to;
    q = rand_vec();
    load(q, q);
    exp_q.push_back(mk(256, 0, 510, 0, 510, 1'b1, 247));
    fork
      launch(100, 100, o, to);
      begin
        repeat (30) @(negedge clk);
        dataBase = ~q; query = rand_vec(); dataBaseValid = 1'b1; queryValid = 1'b1;
        @(negedge clk);
        dataBaseValid = 1'b0; queryValid = 1'b0;
      end
    join
    e = exp_q.pop_front();
    vectors++;
    if (to || o !== e) begin
      miscompares++;
      $display("FAIL db_pulse: got %s timeout=%0b, required %s", fmt(o), to, fmt(e));
    end
  endtask

  task automatic test_random();
    logic [511:0] q, d;
    int qs, ds;
    res_t o, e;
    bit to;
    for (int n = 0; n < 8; n++) begin
      q = rand_vec(); d = rand_vec();
      qs = $urandom_range(0, 255); ds = $urandom_range(0, 255);
      for (int k = -255; k < 256; k++)
        if (qs + k >= 0 && qs + k < 256 && ds + k >= 0 && ds + k < 256 && $urandom_range(0, 3) != 0)
          d = set_base(d, ds + k, get_base(q, qs + k));
      load(q, d);
      exp_q.push_back(model(q, d, qs, ds));
      launch(qs, ds, o, to);
      e = exp_q.pop_front();
      vectors++;
      if (to || o !== e) begin
        miscompares++;
        $display("FAIL random_%0d (qs=%0d ds=%0d): got %s timeout=%0b, required %s", n, qs, ds, fmt(o), to, fmt(e));
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_match();
    test_all_mismatch();
    test_edge_seed();
    test_threshold();
    test_held_start();
    test_reset_mid();
    test_db_pulse();
    test_random();
    vectors++;
    if (hv_stray !== 0) begin
      miscompares++;
      $display("FAIL hsp_without_stop: %0d hspValid pulses outside stop, required 0", hv_stray);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
